// File: rtl/random_generator_bank.sv
// -----------------------------------------------------------------------------
// random_generator_bank
//
// Multi-channel Fibonacci LFSR random source. Each of NUM_CH channels holds
// its own state and stored seed. A channel can be reseeded at run time. After
// reset or any reseed it runs WARMUP discarded steps, then steps on enable.
// It pulses once each time the sequence returns to its stored seed.
// One channel feeds one stochastic sampling lane of the RBM units.
//
// Parameters
//   WIDTH        bits per channel (>= 3)
//   NUM_CH       number of independent channels (>= 1)
//   TAPS         feedback tap mask; bit i set = state[i] enters the XOR
//   DEFAULT_SEED reset seed base; channel c resets to DEFAULT_SEED + c
//   WARMUP       discarded steps after reset / reseed (0..255)
//   CH_W         width of seed_ch (derived)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset for every channel
//   enable       advance every channel that has finished warm-up
//   seed_valid   load seed_data into channel seed_ch this cycle
//   seed_ch      target channel of the load; values >= NUM_CH are ignored
//   seed_data    new seed
//   data_out     channel c state at [c*WIDTH +: WIDTH] (registered)
//   data_valid   channel c has finished warm-up (registered)
//   period_pulse one-cycle pulse when channel c returns to its stored seed
// -----------------------------------------------------------------------------
module random_generator_bank #(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       NUM_CH       = 4,
  parameter logic [WIDTH-1:0]  TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = 8'h01,
  parameter int unsigned       WARMUP       = 4,
  parameter int unsigned       CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    seed_valid,
  input  logic [CH_W-1:0]         seed_ch,
  input  logic [WIDTH-1:0]        seed_data,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       data_valid,
  output logic [NUM_CH-1:0]       period_pulse
);

  // Operating mode of one channel. The mode is decoded from the warm-up
  // counter rather than stored separately, so the two can never disagree.
  typedef enum logic {
    CH_WARM = 1'b0,  // counter > 0: steps every cycle, output not yet valid
    CH_RUN  = 1'b1   // counter == 0: steps only on enable
  } ch_mode_e;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  // One Fibonacci step. The (s == 0) term maps the all-zero state to 1, so a
  // zero seed cannot lock the register up.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ (s == '0);
    return {s[WIDTH-2:0], fb};
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    // Reset seed wraps modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] RST_SEED = DEFAULT_SEED + WIDTH'(c);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q,  seed_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;

    logic [WIDTH-1:0] state_nxt;
    logic             load;
    ch_mode_e         mode;

    assign state_nxt = lfsr_next(state_q);

    // An out-of-range seed_ch matches no channel and is silently dropped.
    assign load = seed_valid && (seed_ch == CH_W'(c));
    assign mode = (cnt_q != 8'd0) ? CH_WARM : CH_RUN;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
      logic step;
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d = state_q;
      seed_d  = seed_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      pulse_d = 1'b0;
      step    = 1'b0;

      if (load) begin
        // A load wins over any step of this channel and restarts warm-up.
        state_d = seed_data;
        seed_d  = seed_data;
        cnt_d   = WARM_INIT;
        valid_d = (WARM_INIT == 8'd0);
      end else begin
        unique case (mode)
          CH_WARM: begin
            step    = 1'b1;
            cnt_d   = cnt_q - 8'd1;
            // Valid rises on the same edge the counter reaches zero.
            valid_d = (cnt_q == 8'd1);
          end
          CH_RUN: begin
            step    = enable;
            valid_d = 1'b1;
          end
          default: ;
        endcase

        if (step) begin
          state_d = state_nxt;
          // Pulse is registered, so it is high in the cycle where data_out
          // shows the stored seed again.
          pulse_d = (state_nxt == seed_q);
        end
      end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: every register, including the stored seed, is reset; a reset
    // must restart each channel from a known seed with a fresh warm-up.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= RST_SEED;
        seed_q  <= RST_SEED;
        cnt_q   <= WARM_INIT;
        valid_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        seed_q  <= seed_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
        pulse_q <= pulse_d;
      end
    end

    assign data_out[c*WIDTH +: WIDTH] = state_q;
    assign data_valid[c]              = valid_q;
    assign period_pulse[c]            = pulse_q;

  end : g_ch

endmodule : random_generator_bank
